pipeline_ctrl: RTL

Stall/flush controller for the 5-stage MIPS pipeline. It detects the hazards that result forwarding cannot cover (load-use, outstanding data-memory access, control redirect, halt) and drives the enable and flush controls of the PC and the four pipeline latches. It sits beside the forwarding unit: that block consumes EX/MEM and MEM/WB results, and this block guarantees those results exist and are stable when consumed.

---
 rtl/pipeline_ctrl_pkg.sv | 6 +
 rtl/pipeline_ctrl_perf_cnt.sv | 24 ++
 rtl/pipeline_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared CPU widths and the pipeline controller state type
package pipeline_ctrl_pkg;
   typedef logic [4:0] regbits_t;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {RUN, DWAIT, HALT} pipe_state_t;
endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// pipeline_ctrl_perf_cnt: stall/flush event counters, present only with PIPE_PERF_CNT_EN defined
`ifdef PIPE_PERF_CNT_EN
module pipeline_ctrl_perf_cnt
   import pipeline_ctrl_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  stall_inc,
   input  logic  flush_inc,
   output word_t stall_cnt,
   output word_t flush_cnt
);
   // free-running wrap-around counters, cleared by reset
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + word_t'(stall_inc);
         flush_cnt <= flush_cnt + word_t'(flush_inc);
      end
   end
endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage pipeline; PIPE_PERF_CNT_EN adds perf counters
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     dmem_req,
   input  logic     idex_memread,
   input  regbits_t idex_wsel,
   input  regbits_t ifid_rs,
   input  regbits_t ifid_rt,
   input  logic     ifid_uses_rt,
   input  logic     pc_redirect,
   input  logic     halt,
   output logic     pc_en,
   output logic     ifid_en,
   output logic     idex_en,
   output logic     exmem_en,
   output logic     memwb_en,
   output logic     ifid_flush,
   output logic     idex_flush,
   output logic     halted
`ifdef PIPE_PERF_CNT_EN
   ,
   output word_t    stall_cnt,
   output word_t    flush_cnt
`endif
);
   pipe_state_t state;
   logic ihit_pend, freeze, fetch_ok, lu;
   logic [6:0] ctl;
   assign freeze = dmem_req && !dhit;
   assign fetch_ok = ihit || ihit_pend;
   assign lu = idex_memread && idex_wsel != '0 &&
               (idex_wsel == ifid_rs || (ifid_uses_rt && idex_wsel == ifid_rt));
   assign halted = state == HALT;
   // control word {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush} by priority
   always_comb begin
      ctl = (!nRST || state == HALT || freeze) ? 7'b00000_00 :
            pc_redirect                          ? 7'b11111_11 :
            lu                                   ? 7'b00111_01 :
                                                   {fetch_ok, 4'b1111, !fetch_ok, 1'b0};
   end
   assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = ctl;
   // state machine and the held-over fetch flag
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= RUN;
         ihit_pend <= 1'b0;
      end else begin
         ihit_pend <= pc_en ? 1'b0 : (ihit_pend || ihit);
         if (state != HALT)
            state <= freeze ? DWAIT : (halt ? HALT : RUN);
      end
   end
`ifdef PIPE_PERF_CNT_EN
   pipeline_ctrl_perf_cnt u_perf (
      .CLK       (CLK),
      .nRST      (nRST),
      .stall_inc (nRST && state != HALT && !pc_en),
      .flush_inc (nRST && state != HALT && pc_redirect && !freeze),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`endif
endmodule
